// File: rtl/cpu_pkg.sv
// Shared definitions for the pipeline datapath: widths and the
// write-back source select encoding.
package cpu_pkg;

  localparam int DATA_W  = 32;
  localparam int REG_AW  = 5;
  localparam int DMEM_AW = 8;

  // Source of the value written back to the register file.
  typedef enum logic {
    WB_ALU = 1'b0,
    WB_MEM = 1'b1
  } wb_sel_e;

  // A memory access is misaligned when it is a load or store to a
  // byte address that is not a multiple of four.
  function automatic logic is_misaligned(input logic mem_access,
                                         input logic [1:0] byte_off);
    return mem_access && (byte_off != 2'b00);
  endfunction

endpackage

// File: rtl/data_mem.sv
// Word-addressed data memory: synchronous write, asynchronous read.
// Contents are never cleared, so stored data survives a reset.
module data_mem #(
  parameter int AW = 8
) (
  input  logic                        clk,
  input  logic                        we,
  input  logic [AW-1:0]               addr,
  input  logic [cpu_pkg::DATA_W-1:0]  wdata,
  output logic [cpu_pkg::DATA_W-1:0]  rdata
);

  logic [cpu_pkg::DATA_W-1:0] mem_q [0:(1<<AW)-1];

  // Write port: a word is committed at the rising edge when enabled.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[addr] <= wdata;
    end
  end

  assign rdata = mem_q[addr];

endmodule

// File: rtl/mem_wb_stage.sv
// MEM stage and MEM/WB pipeline register. Performs the data-memory
// access, resolves beq, and registers the write-back triple. Overflow or
// a misaligned access squashes the architectural effects (store, register
// write, branch) and bumps a saturating event counter.
module mem_wb_stage #(
  parameter int DMEM_AW = cpu_pkg::DMEM_AW,
  parameter int CNT_W   = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [cpu_pkg::DATA_W-1:0]  PC_em,
  input  logic                        Zero_em,
  input  logic                        Overflow_em,
  input  logic [cpu_pkg::DATA_W-1:0]  ALUout_em,
  input  logic [cpu_pkg::REG_AW-1:0]  Rw_em,
  input  logic                        MemWr_em,
  input  logic                        Branch_em,
  input  logic                        MemtoReg_em,
  input  logic                        RegWr_em,
  input  logic [cpu_pkg::DATA_W-1:0]  busB_em,
  output logic                        PCSrc,
  output logic [cpu_pkg::DATA_W-1:0]  BranchTarget,
  output logic [cpu_pkg::DATA_W-1:0]  Di_wb,
  output logic [cpu_pkg::REG_AW-1:0]  Rw_wb,
  output logic                        WE_wb,
  output logic                        Exc_wb,
  output logic [CNT_W-1:0]            ExcCount
);
  import cpu_pkg::*;

  logic [DMEM_AW-1:0] widx;
  logic               misal;
  logic               exc;
  logic               store_en;
  logic [DATA_W-1:0]  mem_rdata;
  wb_sel_e            wb_sel;

  // Upper address bits are deliberately ignored: addresses alias.
  logic unused_addr_bits;
  assign unused_addr_bits = ^ALUout_em[DATA_W-1:DMEM_AW+2];

  assign widx  = ALUout_em[DMEM_AW+1:2];
  assign misal = is_misaligned(MemWr_em | MemtoReg_em, ALUout_em[1:0]);
  assign exc   = Overflow_em | misal;

  // A store is also blocked while reset is asserted.
  assign store_en = MemWr_em & ~exc & reset;

  assign PCSrc        = Branch_em & Zero_em & ~exc;
  assign BranchTarget = PC_em;

  data_mem #(.AW(DMEM_AW)) u_dmem (
    .clk   (clk),
    .we    (store_en),
    .addr  (widx),
    .wdata (busB_em),
    .rdata (mem_rdata)
  );

  assign wb_sel = MemtoReg_em ? WB_MEM : WB_ALU;

  logic [DATA_W-1:0] di_q,  di_d;
  logic [REG_AW-1:0] rw_q,  rw_d;
  logic              we_q,  we_d;
  logic              exc_q, exc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  // Next-state for the MEM/WB register and the saturating event counter.
  always_comb begin
    di_d  = ALUout_em;
    rw_d  = Rw_em;
    we_d  = RegWr_em & ~exc & (Rw_em != '0);
    exc_d = exc;
    cnt_d = cnt_q;
    case (wb_sel)
      WB_MEM:  di_d = mem_rdata;
      default: di_d = ALUout_em;
    endcase
    if (exc && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // MEM/WB register and counter; reset discards any in-flight write-back.
  always_ff @(posedge clk) begin
    if (!reset) begin
      di_q  <= '0;
      rw_q  <= '0;
      we_q  <= 1'b0;
      exc_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      di_q  <= di_d;
      rw_q  <= rw_d;
      we_q  <= we_d;
      exc_q <= exc_d;
      cnt_q <= cnt_d;
    end
  end

  assign Di_wb    = di_q;
  assign Rw_wb    = rw_q;
  assign WE_wb    = we_q;
  assign Exc_wb   = exc_q;
  assign ExcCount = cnt_q;

endmodule
